// File: rtl/nes_input_pkg.sv
// Shared constants and types for the NES controller-port responder.
package nes_input_pkg;

   typedef logic [7:0] pad_t;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam logic [7:0] KC_P1_A      = 8'h0E;
   localparam logic [7:0] KC_P1_B      = 8'h0D;
   localparam logic [7:0] KC_P1_SELECT = 8'h2B;
   localparam logic [7:0] KC_P1_START  = 8'h28;
   localparam logic [7:0] KC_P1_UP     = 8'h1A;
   localparam logic [7:0] KC_P1_DOWN   = 8'h16;
   localparam logic [7:0] KC_P1_LEFT   = 8'h04;
   localparam logic [7:0] KC_P1_RIGHT  = 8'h07;

   localparam logic [7:0] KC_P2_A      = 8'h59;
   localparam logic [7:0] KC_P2_B      = 8'h5A;
   localparam logic [7:0] KC_P2_SELECT = 8'h5B;
   localparam logic [7:0] KC_P2_START  = 8'h58;
   localparam logic [7:0] KC_P2_UP     = 8'h52;
   localparam logic [7:0] KC_P2_DOWN   = 8'h51;
   localparam logic [7:0] KC_P2_LEFT   = 8'h50;
   localparam logic [7:0] KC_P2_RIGHT  = 8'h4F;

   localparam logic [7:0] KC_ROLLOVER  = 8'h01;

   localparam logic [15:0] PAD_ADDR1 = 16'h4016;
   localparam logic [15:0] PAD_ADDR2 = 16'h4017;

   // Opposing directions cancel each other rather than one winning.
   function automatic pad_t socd_clean(input pad_t p);
      pad_t r;
      r = p;
      if (p[BTN_UP] && p[BTN_DOWN]) begin
         r[BTN_UP]   = 1'b0;
         r[BTN_DOWN] = 1'b0;
      end
      if (p[BTN_LEFT] && p[BTN_RIGHT]) begin
         r[BTN_LEFT]  = 1'b0;
         r[BTN_RIGHT] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/nes_pad_shifter.sv
// One controller's latch/shift register: parallel load while strobed, serial out on reads.
module nes_pad_shifter
   import nes_input_pkg::*;
#(
   parameter logic FILL_BIT = 1'b1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic strobe_i,
   input  logic shift_i,
   input  pad_t pad_i,
   output logic bit_o
);

   pad_t sh_q, sh_d;

   always_comb begin
      sh_d = sh_q;
      if (strobe_i) begin
         sh_d = pad_i;
      end else if (shift_i) begin
         sh_d = {FILL_BIT, sh_q[7:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sh_q <= 8'hFF;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign bit_o = sh_q[0];

endmodule

// File: rtl/nes_pad_port.sv
// Decodes HID keycodes into two NES joypads and answers CPU accesses at $4016/$4017.
module nes_pad_port
   import nes_input_pkg::*;
#(
   parameter logic [7:0] OPEN_BUS    = 8'h40,
   parameter bit         SOCD_FILTER = 1'b1,
   parameter logic       FILL_BIT    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_din,
   input  logic [7:0]  keycode,
   input  logic [7:0]  keycode2,
   input  logic [7:0]  keycode3,
   output logic [7:0]  cpu_dout,
   output logic        cpu_dout_sel,
   output logic [7:0]  pad1_state,
   output logic [7:0]  pad2_state
);

   localparam logic [7:0][7:0] P1_MAP = {KC_P1_RIGHT, KC_P1_LEFT, KC_P1_DOWN, KC_P1_UP,
                                         KC_P1_START, KC_P1_SELECT, KC_P1_B, KC_P1_A};
   localparam logic [7:0][7:0] P2_MAP = {KC_P2_RIGHT, KC_P2_LEFT, KC_P2_DOWN, KC_P2_UP,
                                         KC_P2_START, KC_P2_SELECT, KC_P2_B, KC_P2_A};

   pad_t dec1, dec2, raw1, raw2;
   pad_t hold1_q, hold2_q, pad1_q, pad2_q;
   logic rollover;
   logic strobe_q, strobe_d;
   logic [7:0] dout_q, dout_d;
   logic sel_q, sel_d;
   logic wr_pad, rd_p1, rd_p2;
   logic bit1, bit2;
   logic unused_din;

   assign unused_din = ^cpu_din[7:1];

   always_comb begin
      raw1 = '0;
      raw2 = '0;
      for (int b = 0; b < 8; b++) begin
         raw1[b] = (keycode == P1_MAP[b]) | (keycode2 == P1_MAP[b]) | (keycode3 == P1_MAP[b]);
         raw2[b] = (keycode == P2_MAP[b]) | (keycode2 == P2_MAP[b]) | (keycode3 == P2_MAP[b]);
      end
      dec1 = SOCD_FILTER ? socd_clean(raw1) : raw1;
      dec2 = SOCD_FILTER ? socd_clean(raw2) : raw2;
   end

   assign rollover = (keycode == KC_ROLLOVER) | (keycode2 == KC_ROLLOVER) |
                     (keycode3 == KC_ROLLOVER);

   // First sync stage doubles as the rollover hold register.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold1_q <= '0;
         hold2_q <= '0;
         pad1_q  <= '0;
         pad2_q  <= '0;
      end else begin
         if (!rollover) begin
            hold1_q <= dec1;
            hold2_q <= dec2;
         end
         pad1_q <= hold1_q;
         pad2_q <= hold2_q;
      end
   end

   assign wr_pad = cpu_ce & cpu_wr & (cpu_addr == PAD_ADDR1);
   assign rd_p1  = cpu_ce & cpu_rd & (cpu_addr == PAD_ADDR1);
   assign rd_p2  = cpu_ce & cpu_rd & (cpu_addr == PAD_ADDR2);

   always_comb begin
      strobe_d = strobe_q;
      dout_d   = dout_q;
      sel_d    = rd_p1 | rd_p2;
      if (wr_pad) begin
         strobe_d = cpu_din[0];
      end
      if (rd_p1) begin
         dout_d = {OPEN_BUS[7:1], bit1};
      end else if (rd_p2) begin
         dout_d = {OPEN_BUS[7:1], bit2};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_q <= 1'b0;
         dout_q   <= OPEN_BUS;
         sel_q    <= 1'b0;
      end else begin
         strobe_q <= strobe_d;
         dout_q   <= dout_d;
         sel_q    <= sel_d;
      end
   end

   // A strobe write in the same cycle as a read suppresses that read's shift.
   nes_pad_shifter #(.FILL_BIT(FILL_BIT)) u_sh1 (
      .clk_i    (clk),
      .reset_i  (reset),
      .strobe_i (strobe_q),
      .shift_i  (rd_p1 & ~wr_pad),
      .pad_i    (pad1_q),
      .bit_o    (bit1)
   );

   nes_pad_shifter #(.FILL_BIT(FILL_BIT)) u_sh2 (
      .clk_i    (clk),
      .reset_i  (reset),
      .strobe_i (strobe_q),
      .shift_i  (rd_p2 & ~wr_pad),
      .pad_i    (pad2_q),
      .bit_o    (bit2)
   );

   assign cpu_dout     = dout_q;
   assign cpu_dout_sel = sel_q;
   assign pad1_state   = pad1_q;
   assign pad2_state   = pad2_q;

endmodule

// File: tb/tb_nes_pad_port.sv
// Bench for nes_pad_port: decode table, directed bus sequences, random run vs. queue model.
module tb_nes_pad_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_ce = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_din = 8'h00;
   logic [7:0]  keycode = 8'h00;
   logic [7:0]  keycode2 = 8'h00;
   logic [7:0]  keycode3 = 8'h00;
   logic [7:0]  cpu_dout;
   logic        cpu_dout_sel;
   logic [7:0]  pad1_state;
   logic [7:0]  pad2_state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nes_pad_port dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_ce       (cpu_ce),
      .cpu_addr     (cpu_addr),
      .cpu_rd       (cpu_rd),
      .cpu_wr       (cpu_wr),
      .cpu_din      (cpu_din),
      .keycode      (keycode),
      .keycode2     (keycode2),
      .keycode3     (keycode3),
      .cpu_dout     (cpu_dout),
      .cpu_dout_sel (cpu_dout_sel),
      .pad1_state   (pad1_state),
      .pad2_state   (pad2_state)
   );

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned map1 [8] = '{'h0E, 'h0D, 'h2B, 'h28, 'h1A, 'h16, 'h04, 'h07};
   int unsigned map2 [8] = '{'h59, 'h5A, 'h5B, 'h58, 'h52, 'h51, 'h50, 'h4F};
   logic [7:0] m_hold1, m_hold2, m_pad1, m_pad2, m_dout;
   logic       m_sel, m_strobe;
   bit         mq1[$];
   bit         mq2[$];
   bit         model_on = 1'b0;

   function automatic logic [7:0] m_decode(input int pad, input int unsigned k1,
                                           input int unsigned k2, input int unsigned k3);
      logic [7:0] v;
      int unsigned code;
      v = 8'h00;
      for (int b = 0; b < 8; b++) begin
         code = (pad == 1) ? map1[b] : map2[b];
         if (k1 == code || k2 == code || k3 == code) v[b] = 1'b1;
      end
      if (v[4] && v[5]) begin v[4] = 1'b0; v[5] = 1'b0; end
      if (v[6] && v[7]) begin v[6] = 1'b0; v[7] = 1'b0; end
      return v;
   endfunction

   task automatic model_step();
      bit rp1, rp2, wp, b1, b2, roll;
      if (reset) begin
         m_hold1 = 0; m_hold2 = 0; m_pad1 = 0; m_pad2 = 0;
         m_strobe = 0; m_dout = 8'h40; m_sel = 0;
         mq1.delete(); mq2.delete();
         return;
      end
      rp1  = cpu_ce && cpu_rd && cpu_addr == 16'h4016;
      rp2  = cpu_ce && cpu_rd && cpu_addr == 16'h4017;
      wp   = cpu_ce && cpu_wr && cpu_addr == 16'h4016;
      roll = keycode == 8'h01 || keycode2 == 8'h01 || keycode3 == 8'h01;
      // An exhausted queue reads as the fill bit (1).
      b1 = (mq1.size() > 0) ? mq1[0] : 1'b1;
      b2 = (mq2.size() > 0) ? mq2[0] : 1'b1;
      m_sel = rp1 || rp2;
      if (rp1) m_dout = 8'h40 | 8'(b1);
      else if (rp2) m_dout = 8'h40 | 8'(b2);
      if (m_strobe) begin
         mq1.delete(); mq2.delete();
         for (int i = 0; i < 8; i++) begin
            mq1.push_back(m_pad1[i]);
            mq2.push_back(m_pad2[i]);
         end
      end else begin
         if (rp1 && !wp && mq1.size() > 0) void'(mq1.pop_front());
         if (rp2 && !wp && mq2.size() > 0) void'(mq2.pop_front());
      end
      if (wp) m_strobe = cpu_din[0];
      m_pad1 = m_hold1;
      m_pad2 = m_hold2;
      if (!roll) begin
         m_hold1 = m_decode(1, keycode, keycode2, keycode3);
         m_hold2 = m_decode(2, keycode, keycode2, keycode3);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (model_on) begin
            check("model_dout", cpu_dout, m_dout);
            check("model_sel", {7'd0, cpu_dout_sel}, {7'd0, m_sel});
            check("model_pad1", pad1_state, m_pad1);
            check("model_pad2", pad2_state, m_pad2);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_wr(input logic [15:0] a, input logic [7:0] d);
      cpu_ce = 1; cpu_wr = 1; cpu_addr = a; cpu_din = d;
      tick();
      cpu_ce = 0; cpu_wr = 0;
   endtask

   task automatic do_rd(input logic [15:0] a, input logic [7:0] exp, input string nm);
      cpu_ce = 1; cpu_rd = 1; cpu_addr = a;
      tick();
      cpu_ce = 0; cpu_rd = 0;
      check(nm, cpu_dout, exp);
      check({nm, "_sel"}, {7'd0, cpu_dout_sel}, 8'd1);
   endtask

   task automatic set_keys(input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3);
      keycode = k1; keycode2 = k2; keycode3 = k3;
   endtask

   function automatic logic [7:0] rand_kc();
      int unsigned r;
      r = $urandom_range(0, 21);
      if (r < 8) return 8'(map1[r]);
      if (r < 16) return 8'(map2[r - 8]);
      if (r == 16 || r == 17) return 8'h00;
      if (r == 18) return 8'h01;
      return 8'($urandom);
   endfunction

   typedef struct {
      logic [7:0] k1, k2, k3;
      logic [7:0] e1, e2;
   } vec_t;

   vec_t vecs [12];
   logic [7:0] t1_exp [10];
   logic [15:0] addr_pool [4];

   initial begin
      vecs[0]  = '{8'h0E, 8'h00, 8'h00, 8'h01, 8'h00};
      vecs[1]  = '{8'h0D, 8'h2B, 8'h00, 8'h06, 8'h00};
      vecs[2]  = '{8'h1A, 8'h16, 8'h00, 8'h00, 8'h00};
      vecs[3]  = '{8'h04, 8'h07, 8'h28, 8'h08, 8'h00};
      vecs[4]  = '{8'h04, 8'h1A, 8'h00, 8'h50, 8'h00};
      vecs[5]  = '{8'h07, 8'h16, 8'h00, 8'hA0, 8'h00};
      vecs[6]  = '{8'h59, 8'h5A, 8'h5B, 8'h00, 8'h07};
      vecs[7]  = '{8'h58, 8'h52, 8'h50, 8'h00, 8'h58};
      vecs[8]  = '{8'h51, 8'h4F, 8'h00, 8'h00, 8'hA0};
      vecs[9]  = '{8'h50, 8'h4F, 8'h0E, 8'h01, 8'h00};
      vecs[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[11] = '{8'h0E, 8'h59, 8'h33, 8'h01, 8'h01};
      t1_exp = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
      addr_pool = '{16'h4016, 16'h4017, 16'h4015, 16'h4016};

      // Reset state
      tick(2);
      reset = 0;
      check("rst_dout", cpu_dout, 8'h40);
      check("rst_sel", {7'd0, cpu_dout_sel}, 8'd0);
      check("rst_pad1", pad1_state, 8'h00);
      check("rst_pad2", pad2_state, 8'h00);
      model_on = 1;

      // Decode table, two clocks key-to-state
      foreach (vecs[i]) begin
         set_keys(vecs[i].k1, vecs[i].k2, vecs[i].k3);
         tick(2);
         check($sformatf("vec%0d_pad1", i), pad1_state, vecs[i].e1);
         check($sformatf("vec%0d_pad2", i), pad2_state, vecs[i].e2);
      end

      // A + Start serial readout, then fill
      set_keys(8'h0E, 8'h28, 8'h00);
      tick(3);
      do_wr(16'h4016, 8'h01);
      do_wr(16'h4016, 8'h00);
      for (int i = 0; i < 10; i++) do_rd(16'h4016, t1_exp[i], $sformatf("t1_rd%0d", i));

      // SOCD on P2, then Up alone
      set_keys(8'h52, 8'h51, 8'h00);
      tick(3);
      check("socd_pad2", pad2_state, 8'h00);
      keycode2 = 8'h00;
      tick(3);
      check("up_pad2", pad2_state, 8'h10);
      do_wr(16'h4016, 8'h01);
      do_wr(16'h4016, 8'h00);
      for (int i = 0; i < 5; i++)
         do_rd(16'h4017, (i == 4) ? 8'h41 : 8'h40, $sformatf("t2_rd%0d", i));

      // Strobe held high: A tracked live, no shift
      do_wr(16'h4016, 8'h01);
      set_keys(8'h0E, 8'h00, 8'h00);
      tick(3);
      do_rd(16'h4016, 8'h41, "t3_live1a");
      do_rd(16'h4016, 8'h41, "t3_live1b");
      keycode = 8'h00;
      tick(3);
      do_rd(16'h4016, 8'h40, "t3_live0");
      keycode = 8'h0E;
      tick(3);
      do_rd(16'h4016, 8'h41, "t3_live1c");
      do_rd(16'h4017, 8'h40, "t3_p2");
      do_wr(16'h4016, 8'h00);

      // Rollover hold
      set_keys(8'h28, 8'h00, 8'h00);
      tick(3);
      check("ro_start", pad1_state, 8'h08);
      keycode3 = 8'h01;
      tick();
      keycode = 8'h00;
      tick(3);
      check("ro_hold", pad1_state, 8'h08);
      keycode3 = 8'h00;
      tick(3);
      check("ro_release", pad1_state, 8'h00);

      // Same-clock write and read
      do_wr(16'h4016, 8'h01);
      do_wr(16'h4016, 8'h00);
      keycode = 8'h0E;
      tick(3);
      cpu_ce = 1; cpu_wr = 1; cpu_rd = 1; cpu_addr = 16'h4016; cpu_din = 8'h01;
      tick();
      cpu_ce = 0; cpu_wr = 0; cpu_rd = 0;
      check("t5_dout", cpu_dout, 8'h40);
      check("t5_sel1", {7'd0, cpu_dout_sel}, 8'd1);
      tick();
      check("t5_sel0", {7'd0, cpu_dout_sel}, 8'd0);
      check("t5_hold", cpu_dout, 8'h40);
      do_rd(16'h4016, 8'h41, "t5_reload");
      do_wr(16'h4016, 8'h00);

      // Reset mid-sequence
      do_rd(16'h4016, 8'h41, "t6_rd0");
      do_rd(16'h4016, 8'h40, "t6_rd1");
      do_rd(16'h4016, 8'h40, "t6_rd2");
      reset = 1;
      tick();
      reset = 0;
      check("t6_pad1", pad1_state, 8'h00);
      do_rd(16'h4016, 8'h41, "t6_after0");
      do_rd(16'h4016, 8'h41, "t6_after1");
      cpu_rd = 1; cpu_addr = 16'h4016;
      tick();
      cpu_rd = 0;
      check("t6_ce_low", {7'd0, cpu_dout_sel}, 8'd0);
      cpu_ce = 1; cpu_rd = 1; cpu_addr = 16'h4015;
      tick();
      cpu_ce = 0; cpu_rd = 0;
      check("t6_other_addr", {7'd0, cpu_dout_sel}, 8'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         set_keys(rand_kc(), rand_kc(), rand_kc());
         cpu_ce   = ($urandom_range(0, 3) != 0);
         cpu_rd   = ($urandom_range(0, 1) == 1);
         cpu_wr   = ($urandom_range(0, 5) == 0);
         cpu_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : addr_pool[$urandom_range(0, 3)];
         cpu_din  = 8'($urandom);
         reset    = ($urandom_range(0, 299) == 0);
         tick();
      end
      cpu_ce = 0; cpu_rd = 0; cpu_wr = 0; reset = 0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
